// File: rtl/rxblock.sv
// UART receiver on the 16x oversampling clock: start-edge detect, 2-of-3 mid-bit vote.
// Define RXBLOCK_PARITY_EN to add an even-parity bit between data and stop.
module rxblock #(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16
) (
  input  logic                 clk16,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] paral_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam logic [3:0] T_LAST = 4'(OVS - 1);
  localparam logic [3:0] T_S0   = 4'(OVS / 2 - 1);
  localparam logic [3:0] T_S1   = 4'(OVS / 2);
  localparam logic [3:0] T_S2   = 4'(OVS / 2 + 1);
  localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

`ifdef RXBLOCK_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t               r_state, w_state;
  logic                 r_s1, r_s2, r_s3;
  logic [3:0]           r_tick, w_tick;
  logic [2:0]           r_bitcnt, w_bitcnt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg;
  logic [DATA_BITS-1:0] r_data, w_data;
  logic [1:0]           r_samp, w_samp;
  logic                 r_done, w_done;
  logic                 r_ferr, w_ferr;
  logic                 w_fall;
  logic                 w_maj;

`ifdef RXBLOCK_PARITY_EN
  logic r_par, w_par;
  logic r_perr, w_perr;
`endif

  assign w_fall = ~r_s2 & r_s3;
  assign w_maj  = (r_samp[0] & r_samp[1]) |
                  (r_samp[0] & r_s2) |
                  (r_samp[1] & r_s2);

  // Synchronizer resets to the idle level so reset never looks like a start edge
  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= serial_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_samp   <= '0;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef RXBLOCK_PARITY_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_tick   <= w_tick;
      r_bitcnt <= w_bitcnt;
      r_shreg  <= w_shreg;
      r_data   <= w_data;
      r_samp   <= w_samp;
      r_done   <= w_done;
      r_ferr   <= w_ferr;
`ifdef RXBLOCK_PARITY_EN
      r_par    <= w_par;
      r_perr   <= w_perr;
`endif
    end
  end

  always_comb begin
    w_state  = r_state;
    w_tick   = r_tick + 4'd1;
    w_bitcnt = r_bitcnt;
    w_shreg  = r_shreg;
    w_data   = r_data;
    w_samp   = r_samp;
    w_done   = 1'b0;
    w_ferr   = 1'b0;
`ifdef RXBLOCK_PARITY_EN
    w_par    = r_par;
    w_perr   = 1'b0;
`endif
    if (r_tick == T_S0) w_samp[0] = r_s2;
    if (r_tick == T_S1) w_samp[1] = r_s2;

    unique case (r_state)
      IDLE: begin
        w_tick   = '0;
        w_bitcnt = '0;
        if (w_fall) w_state = START;
      end
      START: begin
        if (r_tick == T_S2 && w_maj) begin
          w_state = IDLE;
          w_tick  = '0;
        end else if (r_tick == T_LAST) begin
          w_state = DATA;
        end
      end
      DATA: begin
        if (r_tick == T_S2)
          w_shreg = {w_maj, r_shreg[DATA_BITS-1:1]};
        if (r_tick == T_LAST) begin
          if (r_bitcnt == B_LAST) begin
`ifdef RXBLOCK_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end else begin
            w_bitcnt = r_bitcnt + 3'd1;
          end
        end
      end
`ifdef RXBLOCK_PARITY_EN
      PARITY: begin
        if (r_tick == T_S2) w_par = w_maj;
        if (r_tick == T_LAST) w_state = STOP;
      end
`endif
      STOP: begin
        // Finish at mid-stop so a back-to-back start edge is not missed
        if (r_tick == T_S2) begin
          w_data  = r_shreg;
          w_done  = 1'b1;
          w_ferr  = ~w_maj;
`ifdef RXBLOCK_PARITY_EN
          w_perr  = ^{r_shreg, r_par};
`endif
          w_state = IDLE;
          w_tick  = '0;
        end
      end
      default: begin
        w_state = IDLE;
        w_tick  = '0;
      end
    endcase

    if (!rx_en) begin
      w_state  = IDLE;
      w_tick   = '0;
      w_bitcnt = '0;
      w_data   = r_data;
      w_done   = 1'b0;
      w_ferr   = 1'b0;
`ifdef RXBLOCK_PARITY_EN
      w_perr   = 1'b0;
`endif
    end
  end

  assign paral_data = r_data;
  assign rx_done    = r_done;
  assign frame_err  = r_ferr;
  assign rx_busy    = (r_state != IDLE);
`ifdef RXBLOCK_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rxblock.sv
// Directed and randomized frames for rxblock, checked against a byte-level model.
`timescale 1ns/1ps
module tb_rxblock;

`ifdef RXBLOCK_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int  LAT = PAR_ON ? 173 : 157;
  localparam real BT  = 160.0;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       rx_en;
  logic [7:0] paral_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  rxblock dut (
    .clk16      (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_en      (rx_en),
    .paral_data (paral_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
  } ev_t;

  ev_t  evq[$];
  int   falls_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_dbl = 0;
  int   n_stray = 0;
  int   n_pchg = 0;
  logic par_flip = 1'b0;
  logic prev_done = 1'b0;
  logic prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) evq.push_back('{paral_data, frame_err, parity_err, cyc});
    if (rx_done && prev_done) n_dbl++;
    if ((frame_err || parity_err) && !rx_done) n_stray++;
    if (!rst && !prev_rst && !rx_done && paral_data !== prev_data) n_pchg++;
    prev_done = rx_done;
    prev_rst  = rst;
    prev_data = paral_data;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic stopb, input real bt);
    falls_q.push_back(cyc);
    serial_in = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      #(bt);
    end
    if (PAR_ON) begin
      serial_in = (^d) ^ par_flip;
      #(bt);
    end
    serial_in = stopb;
    #(bt);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d,
                              input logic fe, input logic pe);
    int  w;
    int  lat;
    ev_t e;
    int  f;
    w = 0;
    while (evq.size() == 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    n_cmp++;
    if (evq.size() == 0) begin
      n_err++;
      $error("FAIL %s_seen: no strobe", tag);
    end
    if (evq.size() != 0) begin
      e = evq.pop_front();
      f = (falls_q.size() != 0) ? falls_q.pop_front() : 0;
      lat = e.cyc - f;
      n_cmp++;
      if (e.d !== d) begin
        n_err++;
        $error("FAIL %s_data: got %0h, want %0h", tag, e.d, d);
      end
      n_cmp++;
      if (e.fe !== fe) begin
        n_err++;
        $error("FAIL %s_ferr: got %0h, want %0h", tag, e.fe, fe);
      end
      n_cmp++;
      if (e.pe !== pe) begin
        n_err++;
        $error("FAIL %s_perr: got %0h, want %0h", tag, e.pe, pe);
      end
      n_cmp++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        n_err++;
        $error("FAIL %s_lat: got %0d, want %0d", tag, lat, LAT);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    real        bt;
    int         nev;

    rst = 1'b1;
    serial_in = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (paral_data !== 8'h00) begin
      n_err++;
      $error("FAIL rst_data: got %0h", paral_data);
    end
    n_cmp++;
    if (rx_done !== 1'b0) begin
      n_err++;
      $error("FAIL rst_done: got %0h", rx_done);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_err++;
      $error("FAIL rst_ferr: got %0h", frame_err);
    end
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $error("FAIL rst_perr: got %0h", parity_err);
    end
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $error("FAIL rst_busy: got %0h", rx_busy);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);

    @(posedge clk);
    #2;
    send(8'h8E, 1'b1, BT);
    serial_in = 1'b1;
    #(BT);
    expect_frame("f8e", 8'h8E, 1'b0, 1'b0);
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $error("FAIL f8e_idle: got %0h", rx_busy);
    end

    par_flip = 1'b1;
    @(posedge clk);
    #2;
    send(8'h8E, 1'b1, BT);
    serial_in = 1'b1;
    #(BT);
    expect_frame("f8e_par", 8'h8E, 1'b0, PAR_ON);
    par_flip = 1'b0;

    @(posedge clk);
    #2;
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $error("FAIL glitch_busy: got %0h", rx_busy);
    end
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $error("FAIL glitch_idle: got %0h", rx_busy);
    end
    n_cmp++;
    if (evq.size() != 0) begin
      n_err++;
      $error("FAIL glitch_nostrobe: got %0d", evq.size());
    end

    send(8'h3C, 1'b0, BT);
    expect_frame("brk", 8'h3C, 1'b1, 1'b0);
    #(BT * 40);
    n_cmp++;
    if (evq.size() != 0) begin
      n_err++;
      $error("FAIL brk_noretrig: got %0d", evq.size());
    end
    serial_in = 1'b1;
    #(BT * 2);
    send(8'hC3, 1'b1, BT);
    serial_in = 1'b1;
    #(BT);
    expect_frame("brk_rearm", 8'hC3, 1'b0, 1'b0);

    bt = BT * 1.03;
    send(8'h55, 1'b1, bt);
    send(8'hA3, 1'b1, bt);
    serial_in = 1'b1;
    #(bt);
    expect_frame("b2b0", 8'h55, 1'b0, 1'b0);
    expect_frame("b2b1", 8'hA3, 1'b0, 1'b0);
    nev = evq.size();
    fork
      send(8'h0F, 1'b1, bt);
      begin
        #(bt * 5);
        rx_en = 1'b0;
      end
    join
    falls_q.delete();
    serial_in = 1'b1;
    #(BT);
    n_cmp++;
    if (evq.size() != nev) begin
      n_err++;
      $error("FAIL abort_nostrobe: got %0d, want %0d", evq.size(), nev);
    end
    n_cmp++;
    if (paral_data !== 8'hA3) begin
      n_err++;
      $error("FAIL abort_data: got %0h", paral_data);
    end
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $error("FAIL abort_busy: got %0h", rx_busy);
    end
    rx_en = 1'b1;
    #(BT);

    @(posedge clk);
    #2;
    d = 8'h96;
    serial_in = 1'b0;
    #(BT);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      #(BT);
    end
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $error("FAIL midrst_busy_pre: got %0h", rx_busy);
    end
    rst = 1'b1;
    serial_in = 1'b1;
    #1;
    n_cmp++;
    if (paral_data !== 8'h00) begin
      n_err++;
      $error("FAIL midrst_data: got %0h", paral_data);
    end
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $error("FAIL midrst_busy: got %0h", rx_busy);
    end
    n_cmp++;
    if (rx_done !== 1'b0) begin
      n_err++;
      $error("FAIL midrst_done: got %0h", rx_done);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #(BT * 12);
    n_cmp++;
    if (evq.size() != 0) begin
      n_err++;
      $error("FAIL midrst_nostrobe: got %0d", evq.size());
    end
    send(8'hF0, 1'b1, BT);
    serial_in = 1'b1;
    #(BT);
    expect_frame("post_rst", 8'hF0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      par_flip = 1'($urandom_range(0, 1));
      bt = BT * (1.0 + (real'($urandom_range(0, 50)) - 25.0) / 1000.0);
      send(d, sb, bt);
      if (!sb) begin
        serial_in = 1'b1;
        #(bt * real'($urandom_range(1, 2)));
      end else if ($urandom_range(0, 1) != 0) begin
        serial_in = 1'b1;
        #(bt);
      end
      expect_frame("rnd", d, !sb, PAR_ON && par_flip);
    end
    serial_in = 1'b1;
    #(BT * 2);

    n_cmp++;
    if (evq.size() != 0) begin
      n_err++;
      $error("FAIL no_extra_strobes: got %0d", evq.size());
    end
    n_cmp++;
    if (n_dbl != 0) begin
      n_err++;
      $error("FAIL strobe_width: got %0d", n_dbl);
    end
    n_cmp++;
    if (n_stray != 0) begin
      n_err++;
      $error("FAIL flag_without_done: got %0d", n_stray);
    end
    n_cmp++;
    if (n_pchg != 0) begin
      n_err++;
      $error("FAIL data_change_off_done: got %0d", n_pchg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
